// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue controller slice:
// opcodes, datapath sizes and the issue FSM state encoding.
package alu_pkg;

    localparam int XLEN   = 64;
    localparam int NREGS  = 32;
    localparam int RIDX_W = $clog2(NREGS);
    localparam int IMM_W  = 12;
    localparam int OP_W   = 4;

    typedef logic [OP_W-1:0]   op_t;
    typedef logic [RIDX_W-1:0] ridx_t;
    typedef logic [XLEN-1:0]   xlen_t;

    localparam op_t ALU_AND = 4'd0;
    localparam op_t ALU_OR  = 4'd1;
    localparam op_t ALU_XOR = 4'd2;
    localparam op_t ALU_NOT = 4'd3;
    localparam op_t ALU_SHR = 4'd4;
    localparam op_t ALU_SHL = 4'd5;
    localparam op_t ALU_ADD = 4'd6;
    localparam op_t ALU_SUB = 4'd7;
    localparam op_t ALU_MUL = 4'd8;
    localparam op_t ALU_DIV = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OPER = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_e;

    function automatic logic is_illegal(input op_t op);
        return op > ALU_DIV;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Issue handshake, ALU drive/return and writeback/error signals
// between decode, the issue controller and the ALU.
interface alu_issue_ctrl_if;
    import alu_pkg::*;

    logic             issue_valid;
    logic             issue_ready;
    op_t              issue_op;
    ridx_t            issue_rd;
    ridx_t            issue_rs;
    ridx_t            issue_rt;
    logic             issue_use_imm;
    logic [IMM_W-1:0] issue_imm;

    xlen_t alu_operand1;
    xlen_t alu_operand2;
    op_t   alu_op;
    xlen_t alu_result;

    logic  wb_valid;
    ridx_t wb_rd;
    xlen_t wb_data;
    logic  err_div0;
    logic  err_illegal;

    modport master (
        input  issue_valid, issue_op, issue_rd, issue_rs, issue_rt,
        input  issue_use_imm, issue_imm, alu_result,
        output issue_ready, alu_operand1, alu_operand2, alu_op,
        output wb_valid, wb_rd, wb_data, err_div0, err_illegal
    );

    modport slave (
        output issue_valid, issue_op, issue_rd, issue_rs, issue_rt,
        output issue_use_imm, issue_imm, alu_result,
        input  issue_ready, alu_operand1, alu_operand2, alu_op,
        input  wb_valid, wb_rd, wb_data, err_div0, err_illegal
    );

endinterface

// File: rtl/alu.sv
// Combinational 64-bit integer/logic ALU driven by the issue controller.
// Illegal opcodes and division by zero return 0.
module alu
    import alu_pkg::*;
(
    input  xlen_t operand1,
    input  xlen_t operand2,
    input  op_t   alu_op,
    output xlen_t result
);

    always_comb begin
        result = '0;
        case (alu_op)
            ALU_AND: result = operand1 & operand2;
            ALU_OR:  result = operand1 | operand2;
            ALU_XOR: result = operand1 ^ operand2;
            ALU_NOT: result = ~operand1;
            ALU_SHR: result = operand1 >> operand2[5:0];
            ALU_SHL: result = operand1 << operand2[5:0];
            ALU_ADD: result = operand1 + operand2;
            ALU_SUB: result = operand1 - operand2;
            ALU_MUL: result = operand1 * operand2;
            ALU_DIV: begin
                if (operand2 != '0) begin
                    result = operand1 / operand2;
                end
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_regfile.sv
// NREGS x XLEN register file: two combinational read ports, a debug
// read port, one synchronous write port and synchronous clear.
module alu_regfile
    import alu_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  ridx_t ra1,
    output xlen_t rd1,
    input  ridx_t ra2,
    output xlen_t rd2,
    input  ridx_t dbg_addr,
    output xlen_t dbg_data,
    input  logic  we,
    input  ridx_t wa,
    input  xlen_t wd
);

    xlen_t mem_q [NREGS];
    xlen_t mem_d [NREGS];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[wa] = wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd1      = mem_q[ra1];
    assign rd2      = mem_q[ra2];
    assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: accepts one op, reads operands, drives the ALU,
// captures its result and writes back, one op every four cycles.
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    alu_issue_ctrl_if.master bus,
    input  ridx_t dbg_addr,
    output xlen_t dbg_data
);

    state_e state_q, state_d;

    op_t              op_q, op_d;
    ridx_t            rd_q, rd_d;
    ridx_t            rs_q, rs_d;
    ridx_t            rt_q, rt_d;
    logic             use_imm_q, use_imm_d;
    logic [IMM_W-1:0] imm_q, imm_d;

    xlen_t opnd1_q, opnd1_d;
    xlen_t opnd2_q, opnd2_d;
    op_t   alu_op_q, alu_op_d;

    logic  wb_valid_q, wb_valid_d;
    ridx_t wb_rd_q, wb_rd_d;
    xlen_t wb_data_q, wb_data_d;
    logic  err_div0_q, err_div0_d;
    logic  err_illegal_q, err_illegal_d;

    xlen_t rf_rd1;
    xlen_t rf_rd2;
    xlen_t imm_ext;

    assign imm_ext = {{(XLEN-IMM_W){1'b0}}, imm_q};

    alu_regfile u_regfile (
        .clk      (clk),
        .reset    (reset),
        .ra1      (rs_q),
        .rd1      (rf_rd1),
        .ra2      (rt_q),
        .rd2      (rf_rd2),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (wb_valid_q),
        .wa       (wb_rd_q),
        .wd       (wb_data_q)
    );

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        rd_d          = rd_q;
        rs_d          = rs_q;
        rt_d          = rt_q;
        use_imm_d     = use_imm_q;
        imm_d         = imm_q;
        opnd1_d       = opnd1_q;
        opnd2_d       = opnd2_q;
        alu_op_d      = alu_op_q;
        wb_valid_d    = 1'b0;
        wb_rd_d       = wb_rd_q;
        wb_data_d     = wb_data_q;
        err_div0_d    = 1'b0;
        err_illegal_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.issue_valid) begin
                    op_d      = bus.issue_op;
                    rd_d      = bus.issue_rd;
                    rs_d      = bus.issue_rs;
                    rt_d      = bus.issue_rt;
                    use_imm_d = bus.issue_use_imm;
                    imm_d     = bus.issue_imm;
                    state_d   = ST_OPER;
                end
            end
            ST_OPER: begin
                opnd1_d  = rf_rd1;
                opnd2_d  = use_imm_q ? imm_ext : rf_rd2;
                alu_op_d = op_q;
                state_d  = ST_EXEC;
            end
            ST_EXEC: begin
                // Outcome is registered here so the pulses land in WB.
                if (is_illegal(alu_op_q)) begin
                    err_illegal_d = 1'b1;
                end else if (alu_op_q == ALU_DIV && opnd2_q == '0) begin
                    err_div0_d = 1'b1;
                end else begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = bus.alu_result;
                end
                state_d = ST_WB;
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            op_q          <= '0;
            rd_q          <= '0;
            rs_q          <= '0;
            rt_q          <= '0;
            use_imm_q     <= 1'b0;
            imm_q         <= '0;
            opnd1_q       <= '0;
            opnd2_q       <= '0;
            alu_op_q      <= '0;
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= '0;
            wb_data_q     <= '0;
            err_div0_q    <= 1'b0;
            err_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            rd_q          <= rd_d;
            rs_q          <= rs_d;
            rt_q          <= rt_d;
            use_imm_q     <= use_imm_d;
            imm_q         <= imm_d;
            opnd1_q       <= opnd1_d;
            opnd2_q       <= opnd2_d;
            alu_op_q      <= alu_op_d;
            wb_valid_q    <= wb_valid_d;
            wb_rd_q       <= wb_rd_d;
            wb_data_q     <= wb_data_d;
            err_div0_q    <= err_div0_d;
            err_illegal_q <= err_illegal_d;
        end
    end

    assign bus.issue_ready  = (state_q == ST_IDLE);
    assign bus.alu_operand1 = opnd1_q;
    assign bus.alu_operand2 = opnd2_q;
    assign bus.alu_op       = alu_op_q;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_rd        = wb_rd_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.err_div0     = err_div0_q;
    assign bus.err_illegal  = err_illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl + alu: directed table, corner sequences
// and random ops against a register-array reference model.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  dbg_addr;
    logic [63:0] dbg_data;

    always #5 clk = ~clk;

    alu_issue_ctrl_if bus();

    alu_issue_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    alu u_alu (
        .operand1 (bus.alu_operand1),
        .operand2 (bus.alu_operand2),
        .alu_op   (bus.alu_op),
        .result   (bus.alu_result)
    );

    int checks = 0;
    int errors = 0;

    logic [63:0] mr [32];

    typedef struct packed {
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        use_imm;
        logic [11:0] imm;
        logic        ev;
        logic        ez;
        logic        ei;
        logic [63:0] ed;
    } vec_t;

    localparam int NV = 16;
    vec_t tbl [NV];

    task automatic chk(input string name, input int idx,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [4:0] rd,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic ui, input logic [11:0] imm,
                                input logic ev, input logic ez, input logic ei,
                                input logic [63:0] ed);
        vec_t v;
        v.op = op; v.rd = rd; v.rs = rs; v.rt = rt;
        v.use_imm = ui; v.imm = imm;
        v.ev = ev; v.ez = ez; v.ei = ei; v.ed = ed;
        return v;
    endfunction

    function automatic void model(input logic [3:0] op,
                                  input logic [63:0] a, input logic [63:0] b,
                                  output logic v, output logic z,
                                  output logic i, output logic [63:0] d);
        v = 0; z = 0; i = 0; d = 0;
        if (op >= 10) begin
            i = 1;
        end else if (op == 9 && b == 0) begin
            z = 1;
        end else begin
            v = 1;
            case (op)
                0: d = a & b;
                1: d = a | b;
                2: d = a ^ b;
                3: d = ~a;
                4: d = a >> (b % 64);
                5: d = a << (b % 64);
                6: d = a + b;
                7: d = a - b;
                8: d = a * b;
                default: d = a / b;
            endcase
        end
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [4:0] rd,
                          input logic [4:0] rs, input logic [4:0] rt,
                          input logic ui, input logic [11:0] imm, input int idx,
                          output logic v, output logic z, output logic i,
                          output logic [4:0] wrd, output logic [63:0] wd);
        @(negedge clk);
        chk("ready_idle", idx, bus.issue_ready, 1);
        bus.issue_valid   = 1;
        bus.issue_op      = op;
        bus.issue_rd      = rd;
        bus.issue_rs      = rs;
        bus.issue_rt      = rt;
        bus.issue_use_imm = ui;
        bus.issue_imm     = imm;
        @(posedge clk);
        #1 bus.issue_valid = 0;
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            chk("ready_busy", idx, bus.issue_ready, 0);
            if (c < 3) begin
                chk("early_out", idx,
                    {bus.wb_valid, bus.err_div0, bus.err_illegal}, 0);
            end
        end
        v   = bus.wb_valid;
        z   = bus.err_div0;
        i   = bus.err_illegal;
        wrd = bus.wb_rd;
        wd  = bus.wb_data;
        @(posedge clk);
        #1;
        chk("pulse_end", idx, {bus.wb_valid, bus.err_div0, bus.err_illegal}, 0);
    endtask

    task automatic apply(input logic [3:0] op, input logic [4:0] rd,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic ui, input logic [11:0] imm,
                         input logic ev, input logic ez, input logic ei,
                         input logic [63:0] ed, input int idx);
        logic v, z, i;
        logic [4:0] wrd;
        logic [63:0] wd;
        run_op(op, rd, rs, rt, ui, imm, idx, v, z, i, wrd, wd);
        chk("wb_valid", idx, v, ev);
        chk("err_div0", idx, z, ez);
        chk("err_illegal", idx, i, ei);
        if (ev) begin
            chk("wb_rd", idx, wrd, rd);
            chk("wb_data", idx, wd, ed);
            mr[rd] = ed;
        end
        dbg_addr = rd;
        #1;
        chk("reg_after", idx, dbg_data, mr[rd]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc, ill, wbs;
        logic ev, ez, ei;
        logic [63:0] ed, b;
        logic [3:0] op;
        logic [4:0] rd, rs, rt;
        logic ui;
        logic [11:0] imm;

        tbl[0]  = mk(6, 1, 0, 0, 1, 5, 1, 0, 0, 64'd5);
        tbl[1]  = mk(7, 2, 0, 1, 0, 0, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFB);
        tbl[2]  = mk(6, 3, 0, 0, 1, 100, 1, 0, 0, 64'd100);
        tbl[3]  = mk(9, 4, 3, 0, 0, 0, 0, 1, 0, 64'd0);
        tbl[4]  = mk(12, 6, 1, 2, 0, 0, 0, 0, 1, 64'd0);
        tbl[5]  = mk(6, 7, 0, 0, 1, 1, 1, 0, 0, 64'd1);
        tbl[6]  = mk(5, 8, 7, 0, 1, 68, 1, 0, 0, 64'd16);
        tbl[7]  = mk(5, 9, 7, 0, 1, 32, 1, 0, 0, 64'h1_0000_0000);
        tbl[8]  = mk(8, 10, 9, 9, 0, 0, 1, 0, 0, 64'd0);
        tbl[9]  = mk(3, 11, 0, 1, 0, 0, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        tbl[10] = mk(9, 12, 3, 0, 1, 7, 1, 0, 0, 64'd14);
        tbl[11] = mk(2, 1, 1, 2, 0, 0, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE);
        tbl[12] = mk(4, 13, 11, 0, 1, 60, 1, 0, 0, 64'hF);
        tbl[13] = mk(0, 14, 12, 0, 1, 12'hFF, 1, 0, 0, 64'd14);
        tbl[14] = mk(1, 15, 7, 8, 0, 0, 1, 0, 0, 64'h11);
        tbl[15] = mk(7, 16, 3, 3, 0, 0, 1, 0, 0, 64'd0);

        for (int k = 0; k < 32; k++) mr[k] = '0;
        reset = 1;
        dbg_addr = 0;
        bus.issue_valid = 0;
        bus.issue_op = 0;
        bus.issue_rd = 0;
        bus.issue_rs = 0;
        bus.issue_rt = 0;
        bus.issue_use_imm = 0;
        bus.issue_imm = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;
        chk("rst_ready", 0, bus.issue_ready, 1);
        chk("rst_out", 0, {bus.wb_valid, bus.err_div0, bus.err_illegal}, 0);
        chk("rst_opnd1", 0, bus.alu_operand1, 0);
        chk("rst_opnd2", 0, bus.alu_operand2, 0);
        chk("rst_aluop", 0, bus.alu_op, 0);
        chk("rst_wbdata", 0, bus.wb_data, 0);
        chk("rst_reg", 0, dbg_data, 0);

        for (int n = 0; n < NV; n++) begin
            apply(tbl[n].op, tbl[n].rd, tbl[n].rs, tbl[n].rt,
                  tbl[n].use_imm, tbl[n].imm,
                  tbl[n].ev, tbl[n].ez, tbl[n].ei, tbl[n].ed, n);
        end

        // Valid held across a busy op: accepted again only back in IDLE.
        acc = 0; ill = 0; wbs = 0;
        @(negedge clk);
        bus.issue_valid = 1;
        bus.issue_op = 12;
        bus.issue_rd = 6;
        bus.issue_use_imm = 0;
        for (int k = 0; k < 5; k++) begin
            if (bus.issue_ready) acc++;
            @(posedge clk);
            #1;
            if (bus.err_illegal) ill++;
            if (bus.wb_valid) wbs++;
            @(negedge clk);
        end
        bus.issue_valid = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (bus.err_illegal) ill++;
            if (bus.wb_valid) wbs++;
        end
        chk("held_accepts", 0, acc, 2);
        chk("held_illegal", 0, ill, 2);
        chk("held_wb", 0, wbs, 0);

        for (int n = 0; n < 40; n++) begin
            op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                             : 4'($urandom_range(0, 9));
            rd = 5'($urandom_range(0, 31));
            rs = 5'($urandom_range(0, 31));
            rt = 5'($urandom_range(0, 31));
            ui = 1'($urandom_range(0, 1));
            imm = ($urandom_range(0, 3) == 0) ? 12'd0
                                              : 12'($urandom_range(0, 4095));
            b = ui ? {52'd0, imm} : mr[rt];
            model(op, mr[rs], b, ev, ez, ei, ed);
            apply(op, rd, rs, rt, ui, imm, ev, ez, ei, ed, 100 + n);
        end

        // Reset in EXEC aborts the op with no write.
        @(negedge clk);
        bus.issue_valid = 1;
        bus.issue_op = 6;
        bus.issue_rd = 5;
        bus.issue_rs = 0;
        bus.issue_use_imm = 1;
        bus.issue_imm = 9;
        @(posedge clk);
        #1 bus.issue_valid = 0;
        @(posedge clk);
        #1 reset = 1;
        @(posedge clk);
        #1 reset = 0;
        for (int k = 0; k < 32; k++) mr[k] = '0;
        chk("abort_ready", 0, bus.issue_ready, 1);
        chk("abort_opnd1", 0, bus.alu_operand1, 0);
        chk("abort_aluop", 0, bus.alu_op, 0);
        wbs = 0;
        for (int k = 0; k < 4; k++) begin
            if (bus.wb_valid || bus.err_div0 || bus.err_illegal) wbs++;
            @(posedge clk);
            #1;
        end
        chk("abort_no_wb", 0, wbs, 0);
        dbg_addr = 5;
        #1;
        chk("abort_r5", 0, dbg_data, 0);
        dbg_addr = 3;
        #1;
        chk("abort_r3", 0, dbg_data, 0);

        apply(6, 5, 0, 0, 1, 12'd42, 1, 0, 0, 64'd42, 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
